// File: rtl/ld3320_init_seq_if.sv
// Register-write bus between the LD3320 init sequencer (master) and the bus write engine (slave).
interface ld3320_init_seq_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/ld3320_init_seq.sv
// LD3320 power-up sequencer: chip reset pulse, settle wait, then walk the register-init table
// issuing writes over a req/ack bus or waiting on programmed delay entries.
module ld3320_init_seq #(
  parameter int       TBL_LEN    = 32,
  parameter int       IDX_W      = 8,
  parameter int       SETTLE_CYC = 1000,
  parameter bit [7:0] DELAY_MARK = 8'hFF,
  parameter int       DELAY_UNIT = 256,
  parameter int       ACK_TO     = 4095,
  parameter int       CNT_W      = 24
) (
  input  logic              clk_d3,
  input  logic              sys_rstn,
  input  logic              start,
  output logic              rst_ena,
  input  logic              rst_done,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [7:0]        tbl_addr,
  input  logic [7:0]        tbl_data,
  ld3320_init_seq_if.master wr_bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST      = 4'd1,
    S_RST_WAIT = 4'd2,
    S_SETTLE   = 4'd3,
    S_FETCH    = 4'd4,
    S_WRITE    = 4'd5,
    S_DELAY    = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LD    = CNT_W'(ACK_TO);
  localparam logic [CNT_W-1:0] UNIT_C    = CNT_W'(DELAY_UNIT);
  localparam logic [IDX_W-1:0] TBL_END   = IDX_W'(TBL_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_zero_s;
  logic             tbl_end_s;
  logic             is_delay_s;
  logic             zero_delay_s;
  logic [CNT_W-1:0] delay_ld_s;
  logic             rst_ena_nx_s;
  logic             wr_req_nx_s;
  logic             busy_nx_s;
  logic             done_nx_s;
  logic             err_nx_s;

  assign cnt_zero_s   = (cnt_r == CNT_ZERO);
  assign tbl_end_s    = (tbl_idx == TBL_END);
  assign is_delay_s   = (tbl_addr == DELAY_MARK);
  assign zero_delay_s = (tbl_data == 8'h00);
  // Product formed at full counter width so large delay counts never wrap.
  assign delay_ld_s   = ({{(CNT_W-8){1'b0}}, tbl_data} * UNIT_C) - CNT_ONE;

  // State register; status outputs registered from the next state so they track it exactly.
  always_ff @(posedge clk_d3 or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_r       <= S_IDLE;
      rst_ena       <= 1'b0;
      wr_bus.wr_req <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      rst_ena       <= rst_ena_nx_s;
      wr_bus.wr_req <= wr_req_nx_s;
      busy          <= busy_nx_s;
      done          <= done_nx_s;
      err           <= err_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx_s = S_RST;
        else       state_nx_s = state_r;
      end
      S_RST:      state_nx_s = S_RST_WAIT;
      S_RST_WAIT: begin
        if (rst_done) state_nx_s = S_SETTLE;
        else          state_nx_s = S_RST_WAIT;
      end
      S_SETTLE: begin
        if (cnt_zero_s) state_nx_s = S_FETCH;
        else            state_nx_s = S_SETTLE;
      end
      S_FETCH: begin
        if (tbl_end_s)         state_nx_s = S_DONE;
        else if (!is_delay_s)  state_nx_s = S_WRITE;
        else if (zero_delay_s) state_nx_s = S_FETCH;
        else                   state_nx_s = S_DELAY;
      end
      // An ack on the final timeout cycle still counts as a completed write.
      S_WRITE: begin
        if (wr_bus.wr_ack)   state_nx_s = S_FETCH;
        else if (cnt_zero_s) state_nx_s = S_ERR;
        else                 state_nx_s = S_WRITE;
      end
      S_DELAY: begin
        if (cnt_zero_s) state_nx_s = S_FETCH;
        else            state_nx_s = S_DELAY;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output decode from the next state, consumed by the output registers.
  always_comb begin
    rst_ena_nx_s = (state_nx_s == S_RST);
    wr_req_nx_s  = (state_nx_s == S_WRITE);
    done_nx_s    = (state_nx_s == S_DONE);
    err_nx_s     = (state_nx_s == S_ERR);
    busy_nx_s    = !((state_nx_s == S_IDLE) || (state_nx_s == S_DONE) || (state_nx_s == S_ERR));
  end

  // Shared wait/timeout counter, table index and latched write payload.
  always_ff @(posedge clk_d3 or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_r          <= CNT_ZERO;
      tbl_idx        <= {IDX_W{1'b0}};
      wr_bus.wr_addr <= 8'h00;
      wr_bus.wr_data <= 8'h00;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) tbl_idx <= {IDX_W{1'b0}};
        end
        S_RST_WAIT: begin
          if (rst_done) cnt_r <= SETTLE_LD;
        end
        S_SETTLE: begin
          if (!cnt_zero_s) cnt_r <= cnt_r - CNT_ONE;
        end
        S_FETCH: begin
          if (!tbl_end_s) begin
            if (!is_delay_s) begin
              wr_bus.wr_addr <= tbl_addr;
              wr_bus.wr_data <= tbl_data;
              cnt_r          <= ACK_LD;
            end else if (zero_delay_s) begin
              tbl_idx <= tbl_idx + IDX_ONE;
            end else begin
              cnt_r <= delay_ld_s;
            end
          end
        end
        S_WRITE: begin
          if (wr_bus.wr_ack)   tbl_idx <= tbl_idx + IDX_ONE;
          else if (!cnt_zero_s) cnt_r  <= cnt_r - CNT_ONE;
        end
        S_DELAY: begin
          if (cnt_zero_s) tbl_idx <= tbl_idx + IDX_ONE;
          else            cnt_r   <= cnt_r - CNT_ONE;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ld3320_init_seq.sv
// Scoreboard bench for ld3320_init_seq: expected writes are queued per sequence and a
// negedge monitor checks payload, request length, inter-write gap and settle latency.
module tb_ld3320_init_seq;
  localparam int TBL_LEN    = 3;
  localparam int SETTLE_CYC = 4;
  localparam int DELAY_UNIT = 4;
  localparam int ACK_TO     = 8;

  logic       clk_d3   = 1'b0;
  logic       sys_rstn = 1'b0;
  logic       start    = 1'b0;
  logic       rst_done = 1'b0;
  logic       rst_ena, busy, done, err;
  logic [7:0] tbl_idx, tbl_addr, tbl_data;

  ld3320_init_seq_if bus ();

  ld3320_init_seq #(
    .TBL_LEN(TBL_LEN), .IDX_W(8), .SETTLE_CYC(SETTLE_CYC), .DELAY_MARK(8'hFF),
    .DELAY_UNIT(DELAY_UNIT), .ACK_TO(ACK_TO), .CNT_W(16)
  ) dut (
    .clk_d3(clk_d3), .sys_rstn(sys_rstn), .start(start), .rst_ena(rst_ena),
    .rst_done(rst_done), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .wr_bus(bus.master), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_d3 = ~clk_d3;

  logic [7:0] t_addr [0:3];
  logic [7:0] t_data [0:3];
  int         ack_cfg [0:3];

  assign tbl_addr = (tbl_idx < 8'd4) ? t_addr[tbl_idx[1:0]] : 8'h00;
  assign tbl_data = (tbl_idx < 8'd4) ? t_data[tbl_idx[1:0]] : 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Write engine model: ack in the k-th cycle of a request (k=0 means never ack).
  int req_cyc = 0;
  initial bus.wr_ack = 1'b0;
  always @(posedge clk_d3) begin
    #2;
    if (bus.wr_req) begin
      req_cyc++;
      bus.wr_ack = (ack_cfg[tbl_idx[1:0]] != 0) && (req_cyc == ack_cfg[tbl_idx[1:0]]);
    end else begin
      req_cyc    = 0;
      bus.wr_ack = 1'b0;
    end
  end

  // Reset sub-block model: rst_done pulses two cycles after rst_ena.
  int rd_cnt = 0;
  always @(posedge clk_d3) begin
    #2;
    rst_done = 1'b0;
    if (rst_ena) rd_cnt = 2;
    else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) rst_done = 1'b1;
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         len;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic cur_ok   = 1'b0;
  logic in_req   = 1'b0;
  logic rd_armed = 1'b0;
  int   len_cnt  = 0;
  int   low_cnt  = 0;
  int   since_rd = 0;
  int   n_rst_ena = 0;

  always @(negedge clk_d3) begin
    if (!sys_rstn) begin
      in_req   = 1'b0;
      rd_armed = 1'b0;
      low_cnt  = 0;
    end else begin
      if (rst_ena) n_rst_ena++;
      if (rd_armed) since_rd++;
      if (rst_done) begin
        rd_armed = 1'b1;
        since_rd = 0;
      end
      if (bus.wr_req && !in_req) begin
        in_req  = 1'b1;
        len_cnt = 1;
        check("write_expected", longint'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          cur    = sb.pop_front();
          cur_ok = 1'b1;
          check("wr_addr", bus.wr_addr, cur.a);
          check("wr_data", bus.wr_data, cur.d);
          if (cur.gap >= 0) check("gap", low_cnt, cur.gap);
        end else begin
          cur_ok = 1'b0;
        end
        if (rd_armed) begin
          check("settle_lat", since_rd, SETTLE_CYC + 2);
          rd_armed = 1'b0;
        end
        low_cnt = 0;
      end else if (bus.wr_req) begin
        len_cnt++;
        if (cur_ok) begin
          check("wr_addr_hold", bus.wr_addr, cur.a);
          check("wr_data_hold", bus.wr_data, cur.d);
        end
      end else begin
        if (in_req) begin
          in_req = 1'b0;
          if (cur_ok) check("req_len", len_cnt, cur.len);
        end
        low_cnt++;
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d, input int len, input int gap);
    exp_t e;
    e.a = a; e.d = d; e.len = len; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic set_tbl(input logic [7:0] a0, input logic [7:0] d0, input logic [7:0] a1,
                         input logic [7:0] d1, input logic [7:0] a2, input logic [7:0] d2);
    t_addr[0] = a0; t_data[0] = d0;
    t_addr[1] = a1; t_data[1] = d1;
    t_addr[2] = a2; t_data[2] = d2;
  endtask

  task automatic set_ack(input int k0, input int k1, input int k2);
    ack_cfg[0] = k0; ack_cfg[1] = k1; ack_cfg[2] = k2;
  endtask

  task automatic pulse_start();
    @(posedge clk_d3); #2 start = 1'b1;
    @(posedge clk_d3); #2 start = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_d3);
      if (done || err) break;
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_d3);
      if (bus.wr_req) break;
    end
    check("req_seen", bus.wr_req, 1);
  endtask

  task automatic check_done(input string nm, input int idx);
    @(negedge clk_d3);
    check({nm, "_done"}, done, 1);
    check({nm, "_err"}, err, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_idx"}, tbl_idx, idx);
    check({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    t_addr[3] = 8'h00; t_data[3] = 8'h00; ack_cfg[3] = 0;
    set_tbl(8'h05, 8'h11, 8'h06, 8'h22, 8'h07, 8'h33);
    set_ack(3, 3, 3);

    // Reset state
    repeat (3) @(posedge clk_d3);
    #1;
    check("rst_rst_ena", rst_ena, 0);
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_idx", tbl_idx, 0);
    @(posedge clk_d3); #2 sys_rstn = 1'b1;

    // Nominal three writes
    n_rst_ena = 0;
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 1); push(8'h07, 8'h33, 3, 1);
    pulse_start();
    check("nom_busy_after_start", busy, 1);
    wait_end();
    check_done("nom", 3);
    check("nom_rst_ena_count", n_rst_ena, 1);

    // Delay entry of 3 units: FETCH + 12 delay cycles + FETCH between writes
    set_tbl(8'h05, 8'h11, 8'hFF, 8'h03, 8'h06, 8'h22);
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 14);
    pulse_start();
    wait_end();
    check_done("dly", 3);

    // Zero delay entry: only the two FETCH cycles separate the writes
    set_tbl(8'h05, 8'h11, 8'hFF, 8'h00, 8'h06, 8'h22);
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 2);
    pulse_start();
    wait_end();
    check_done("dly0", 3);

    // Ack timeout on entry 1
    set_tbl(8'h05, 8'h11, 8'h06, 8'h22, 8'h07, 8'h33);
    set_ack(3, 0, 3);
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, ACK_TO + 1, 1);
    pulse_start();
    wait_end();
    @(negedge clk_d3);
    check("to_err", err, 1);
    check("to_done", done, 0);
    check("to_busy", busy, 0);
    check("to_idx", tbl_idx, 1);
    check("to_wr_req", bus.wr_req, 0);
    check("to_sb_empty", sb.size(), 0);

    // Restart from ERR clears err and reruns from index 0
    set_ack(3, 3, 3);
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 1); push(8'h07, 8'h33, 3, 1);
    pulse_start();
    check("rerun_err_clr", err, 0);
    check("rerun_idx0", tbl_idx, 0);
    wait_end();
    check_done("rerun", 3);

    // Ack lands in the same cycle the timeout counter hits zero
    set_ack(3, ACK_TO + 1, 3);
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, ACK_TO + 1, 1); push(8'h07, 8'h33, 3, 1);
    pulse_start();
    wait_end();
    check_done("ackedge", 3);

    // start during WRITE is ignored
    set_ack(3, 3, 3);
    n_rst_ena = 0;
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 1); push(8'h07, 8'h33, 3, 1);
    pulse_start();
    wait_req();
    pulse_start();
    wait_end();
    check_done("busy_start", 3);
    check("busy_start_rst_ena", n_rst_ena, 1);

    // Restart from DONE runs a full new sequence
    n_rst_ena = 0;
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 1); push(8'h07, 8'h33, 3, 1);
    pulse_start();
    wait_end();
    check_done("restart", 3);
    check("restart_rst_ena", n_rst_ena, 1);

    // Asynchronous reset in the middle of a write
    push(8'h05, 8'h11, 3, -1); push(8'h06, 8'h22, 3, 1); push(8'h07, 8'h33, 3, 1);
    pulse_start();
    wait_req();
    @(posedge clk_d3); #2 sys_rstn = 1'b0;
    #1;
    check("arst_wr_req", bus.wr_req, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_rst_ena", rst_ena, 0);
    sb.delete();
    repeat (2) @(posedge clk_d3);
    #2 sys_rstn = 1'b1;
    n_rst_ena = 0;
    repeat (20) @(posedge clk_d3);
    #1;
    check("post_busy", busy, 0);
    check("post_idx", tbl_idx, 0);
    check("post_done", done, 0);
    check("post_err", err, 0);
    check("post_rst_ena_count", n_rst_ena, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
